memory_cycle: RTL and testbench
===============================

// Module: memory_cycle
// PURPOSE
//   Memory stage of the 5-stage RV32 pipeline; consumes the E/M register outputs of the Execute stage.
//   Issues loads/stores to the data memory over a req/ready handshake.
//   Raises StallM while an access is outstanding and loads the M/W pipeline register.
//   Enters a sticky fault state on a misaligned address or a bus timeout.
// PARAMETERS
//   TIMEOUT_CYCLES  16  WAIT cycles allowed without dmem_ready before fault (>=1)
//   CNT_W           5   wait-counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//   clk           in   1   clock, all state on posedge
//   rst           in   1   synchronous active-low reset
//   RegWriteM     in   1   E/M: register write enable
//   MemWriteM     in   1   E/M: store
//   ResultSrcM    in   1   E/M: 1 = load (result from memory)
//   RD_M          in   5   E/M: destination register
//   PCPlus4M      in   32  E/M: PC+4
//   ALU_ResultM   in   32  E/M: effective address / ALU result
//   WriteDataM    in   32  E/M: store data (already forwarded)
//   dmem_req      out  1   access request
//   dmem_we       out  1   1 = write
//   dmem_addr     out  32  word address (byte address, [1:0]=0)
//   dmem_wdata    out  32  store data
//   dmem_ready    in   1   access complete this cycle; rdata valid if read
//   dmem_rdata    in   32  load data
//   StallM        out  1   hold PC, F/D, D/E and E/M registers this cycle
//   RegWriteW, ResultSrcW  out 1, 1   M/W register
//   RD_W          out  5   M/W register
//   PCPlus4W, ALU_ResultW, ReadDataW  out 32 each   M/W register
//   FaultW        out  1   sticky fault flag
//   FaultCodeW    out  2   00 none, 01 misaligned, 10 timeout
// BEHAVIOUR
//   Reset: rst==0 at posedge -> state IDLE, wait count 0, all M/W outputs 0, FaultW 0, FaultCodeW 00.
//     While rst==0, dmem_req and StallM are forced 0.
//   access = MemWriteM | ResultSrcM. dmem_addr = ALU_ResultM, dmem_wdata = WriteDataM, dmem_we = MemWriteM
//     (combinational). Upstream holds all E/M inputs stable while StallM=1.
//   Misalign: access & ALU_ResultM[1:0]!=0 in IDLE -> no request issued.
//     Next state ERR, FaultCodeW=01, M/W loaded as bubble.
//   IDLE: aligned access -> dmem_req=1.
//     dmem_ready=1 same cycle: zero-wait completion, StallM=0, M/W loads, stay IDLE.
//     Else StallM=1, M/W loads bubble (RegWriteW=0, ResultSrcW=0), count<=0, go WAIT.
//     No access: M/W loads E/M values (ALU/JAL result path), ReadDataW=0.
//   WAIT: dmem_req=1 with unchanged addr/data/we.
//     dmem_ready=1: StallM=0, M/W loads, ReadDataW=dmem_rdata (0 for stores), go IDLE.
//     Else StallM=1, bubble into M/W, count++.
//     count==TIMEOUT_CYCLES-1 & !ready: go ERR, FaultCodeW=10.
//     ready on the final allowed cycle wins over timeout.
//   ERR: dmem_req=0, StallM=1 permanently, M/W holds bubble, FaultW=1; exit only via reset.
//   M/W latency: one cycle after completion, values appear on the *W outputs for exactly one cycle,
//     then the next instruction or a bubble follows.
//   Reset mid-access: request dropped at once; a late dmem_ready afterwards is ignored (state IDLE, no access).
//   Store with RegWriteM=1 is passed through unchanged; no check is performed.
// TESTING
//   ALU-only: RegWriteM=1, RD_M=5, ALU_ResultM=0x1234, no access.
//     -> next cycle RegWriteW=1, RD_W=5, ALU_ResultW=0x1234, StallM never 1.
//   Zero-wait load: ResultSrcM=1, addr 0x100, ready same cycle, rdata 0xDEADBEEF.
//     -> no stall; next cycle ReadDataW=0xDEADBEEF, ResultSrcW=1.
//   3-wait store: MemWriteM=1, addr 0x40, wdata 0xA5A5A5A5, ready on 4th cycle.
//     -> StallM=1 for 3 cycles, req/addr/wdata stable, bubble in M/W, then completion.
//   Timeout: load, ready never asserted.
//     -> after 1+16 cycles FaultW=1, FaultCodeW=10, dmem_req=0, StallM stays 1.
//     Ready on cycle 16 instead -> normal completion.
//   Misaligned: load at 0x102 -> dmem_req never asserted, next cycle FaultCodeW=01, StallM=1.
//   Reset mid-WAIT: rst=0 during cycle 2 of a wait.
//     -> next cycle all outputs 0, IDLE; a subsequent dmem_ready causes no M/W update.

Source files
------------

// File: rtl/memory_cycle.sv
// Memory stage of the RV32 pipeline: issues data-memory accesses and loads the M/W register.
// Latency: zero-wait accesses complete in the issuing cycle; M/W outputs update one cycle after completion.
// Backpressure: StallM holds upstream while an access is outstanding or after a sticky fault.
module memory_cycle #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        FaultW,
  output logic [1:0]  FaultCodeW
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             reg_write_q, result_src_q, fault_q;
  logic [4:0]       rd_q;
  logic [31:0]      pc_plus4_q, alu_result_q, read_data_q;
  logic [1:0]       fault_code_q;

  logic access;
  logic misaligned;
  logic mw_load_d;
  logic timeout_d;

  assign access     = MemWriteM | ResultSrcM;
  assign misaligned = access & (ALU_ResultM[1:0] != 2'b00);

  // The bus sees the E/M values directly; upstream keeps them stable while stalled.
  assign dmem_addr  = ALU_ResultM;
  assign dmem_wdata = WriteDataM;
  assign dmem_we    = MemWriteM;

  // Request/stall decode: a misaligned access never reaches the bus and holds the pipe.
  always_comb begin
    dmem_req  = 1'b0;
    StallM    = 1'b0;
    mw_load_d = 1'b0;
    timeout_d = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (misaligned) begin
            StallM = 1'b1;
          end else if (access) begin
            dmem_req  = 1'b1;
            StallM    = ~dmem_ready;
            mw_load_d = dmem_ready;
          end else begin
            mw_load_d = 1'b1;
          end
        end
        WAIT: begin
          dmem_req  = 1'b1;
          StallM    = ~dmem_ready;
          mw_load_d = dmem_ready;
          timeout_d = ~dmem_ready & (cnt_q == CNT_LAST);
        end
        default: begin
          StallM = 1'b1;
        end
      endcase
    end
  end

  // Access FSM with registered M/W and fault outputs; anything not loaded is a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
    end else begin
      if (mw_load_d) begin
        reg_write_q  <= RegWriteM;
        result_src_q <= ResultSrcM;
        rd_q         <= RD_M;
        pc_plus4_q   <= PCPlus4M;
        alu_result_q <= ALU_ResultM;
        read_data_q  <= ResultSrcM ? dmem_rdata : 32'd0;
      end else begin
        reg_write_q  <= 1'b0;
        result_src_q <= 1'b0;
        rd_q         <= '0;
        pc_plus4_q   <= '0;
        alu_result_q <= '0;
        read_data_q  <= '0;
      end

      case (state_q)
        IDLE: begin
          if (misaligned) begin
            state_q      <= ERR;
            fault_q      <= 1'b1;
            fault_code_q <= CODE_MISALIGN;
          end else if (access && !dmem_ready) begin
            state_q <= WAIT;
            cnt_q   <= '0;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            state_q <= IDLE;
          end else if (timeout_d) begin
            state_q      <= ERR;
            fault_q      <= 1'b1;
            fault_code_q <= CODE_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign RegWriteW   = reg_write_q;
  assign ResultSrcW  = result_src_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pc_plus4_q;
  assign ALU_ResultW = alu_result_q;
  assign ReadDataW   = read_data_q;
  assign FaultW      = fault_q;
  assign FaultCodeW  = fault_code_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: ALU pass-through, zero-wait load, waited store,
// timeout edge and fault, misaligned fault, and reset in the middle of a wait.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        StallM;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic        FaultW;
  logic [1:0]  FaultCodeW;

  int total = 0;
  int bad   = 0;

  memory_cycle #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .FaultW(FaultW), .FaultCodeW(FaultCodeW)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_em();
    RegWriteM   = 1'b0;
    MemWriteM   = 1'b0;
    ResultSrcM  = 1'b0;
    RD_M        = 5'd0;
    PCPlus4M    = 32'd0;
    ALU_ResultM = 32'd0;
    WriteDataM  = 32'd0;
    dmem_ready  = 1'b0;
    dmem_rdata  = 32'd0;
  endtask

  initial begin
    rst = 1'b0;
    clear_em();
    ResultSrcM = 1'b1;
    tick();
    tick();
    // Reset state, with an access presented during reset
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_regwrite", 32'(RegWriteW), 32'd0);
    chk("rst_readdata", ReadDataW, 32'd0);
    chk("rst_fault", 32'(FaultW), 32'd0);
    chk("rst_code", 32'(FaultCodeW), 32'd0);

    // ALU-only instruction passes straight through
    rst = 1'b1;
    clear_em();
    RegWriteM = 1'b1; RD_M = 5'd5; ALU_ResultM = 32'h1234; PCPlus4M = 32'h8;
    settle();
    chk("alu_stall", 32'(StallM), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);
    tick();
    chk("alu_regwrite", 32'(RegWriteW), 32'd1);
    chk("alu_rd", 32'(RD_W), 32'd5);
    chk("alu_result", ALU_ResultW, 32'h1234);
    chk("alu_pc4", PCPlus4W, 32'h8);
    chk("alu_readdata", ReadDataW, 32'd0);

    // Zero-wait load
    clear_em();
    RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd7; ALU_ResultM = 32'h100;
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    settle();
    chk("zl_req", 32'(dmem_req), 32'd1);
    chk("zl_we", 32'(dmem_we), 32'd0);
    chk("zl_addr", dmem_addr, 32'h100);
    chk("zl_stall", 32'(StallM), 32'd0);
    tick();
    chk("zl_readdata", ReadDataW, 32'hDEADBEEF);
    chk("zl_resultsrc", 32'(ResultSrcW), 32'd1);
    chk("zl_rd", 32'(RD_W), 32'd7);

    // Store completing on the 4th cycle
    clear_em();
    MemWriteM = 1'b1; ALU_ResultM = 32'h40; WriteDataM = 32'hA5A5A5A5;
    settle();
    chk("st_c1_req", 32'(dmem_req), 32'd1);
    chk("st_c1_we", 32'(dmem_we), 32'd1);
    chk("st_c1_stall", 32'(StallM), 32'd1);
    tick();
    chk("st_c2_stall", 32'(StallM), 32'd1);
    chk("st_c2_req", 32'(dmem_req), 32'd1);
    chk("st_c2_addr", dmem_addr, 32'h40);
    chk("st_c2_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_c2_bubble_rw", 32'(RegWriteW), 32'd0);
    chk("st_c2_bubble_rs", 32'(ResultSrcW), 32'd0);
    tick();
    chk("st_c3_stall", 32'(StallM), 32'd1);
    chk("st_c3_req", 32'(dmem_req), 32'd1);
    tick();
    dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
    settle();
    chk("st_c4_stall", 32'(StallM), 32'd0);
    tick();
    chk("st_done_alu", ALU_ResultW, 32'h40);
    chk("st_done_readdata", ReadDataW, 32'd0);
    chk("st_done_fault", 32'(FaultW), 32'd0);
    clear_em();
    tick();
    chk("st_next_alu", ALU_ResultW, 32'd0);

    // Ready on the last allowed wait cycle completes normally
    clear_em();
    RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd9; ALU_ResultM = 32'h200;
    settle();
    chk("edge_c1_stall", 32'(StallM), 32'd1);
    repeat (16) tick();
    chk("edge_last_stall", 32'(StallM), 32'd1);
    chk("edge_last_req", 32'(dmem_req), 32'd1);
    dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
    settle();
    chk("edge_last_ready_stall", 32'(StallM), 32'd0);
    tick();
    chk("edge_readdata", ReadDataW, 32'hCAFEF00D);
    chk("edge_rd", 32'(RD_W), 32'd9);
    chk("edge_fault", 32'(FaultW), 32'd0);

    // Timeout: ready never comes
    clear_em();
    RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd3; ALU_ResultM = 32'h300;
    repeat (16) tick();
    chk("to_last_stall", 32'(StallM), 32'd1);
    chk("to_last_fault", 32'(FaultW), 32'd0);
    tick();
    chk("to_fault", 32'(FaultW), 32'd1);
    chk("to_code", 32'(FaultCodeW), 32'd2);
    chk("to_req", 32'(dmem_req), 32'd0);
    chk("to_stall", 32'(StallM), 32'd1);
    chk("to_bubble", 32'(RegWriteW), 32'd0);
    dmem_ready = 1'b1;
    tick();
    chk("to_sticky_fault", 32'(FaultW), 32'd1);
    chk("to_sticky_stall", 32'(StallM), 32'd1);
    chk("to_sticky_req", 32'(dmem_req), 32'd0);

    // Reset clears the fault
    rst = 1'b0;
    clear_em();
    tick();
    rst = 1'b1;
    chk("clr_fault", 32'(FaultW), 32'd0);
    chk("clr_code", 32'(FaultCodeW), 32'd0);

    // Misaligned load
    RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd4; ALU_ResultM = 32'h102;
    settle();
    chk("mis_req", 32'(dmem_req), 32'd0);
    tick();
    chk("mis_next_req", 32'(dmem_req), 32'd0);
    chk("mis_code", 32'(FaultCodeW), 32'd1);
    chk("mis_fault", 32'(FaultW), 32'd1);
    chk("mis_stall", 32'(StallM), 32'd1);
    chk("mis_bubble", 32'(RegWriteW), 32'd0);

    rst = 1'b0;
    clear_em();
    tick();
    rst = 1'b1;

    // Reset during the second wait cycle of a store
    MemWriteM = 1'b1; ALU_ResultM = 32'h80; WriteDataM = 32'h12345678; RegWriteM = 1'b1; RD_M = 5'd2;
    tick();
    tick();
    chk("rw_pre_stall", 32'(StallM), 32'd1);
    rst = 1'b0;
    settle();
    chk("rw_req_drop", 32'(dmem_req), 32'd0);
    chk("rw_stall_drop", 32'(StallM), 32'd0);
    tick();
    chk("rw_regwrite", 32'(RegWriteW), 32'd0);
    chk("rw_alu", ALU_ResultW, 32'd0);
    chk("rw_fault", 32'(FaultW), 32'd0);
    rst = 1'b1;
    clear_em();
    dmem_ready = 1'b1; dmem_rdata = 32'h55555555;
    settle();
    chk("rw_late_req", 32'(dmem_req), 32'd0);
    tick();
    chk("rw_late_readdata", ReadDataW, 32'd0);
    chk("rw_late_regwrite", 32'(RegWriteW), 32'd0);
    chk("rw_late_stall", 32'(StallM), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
